// File: rtl/conv_sequencer_if.sv
// rtl/conv_sequencer_if.sv - control/bank bus between the register block and conv_sequencer
interface conv_sequencer_if #(
  parameter int ADDR_W  = 10,
  parameter int N_BANKS = 3
);
  logic               i_load;
  logic               i_run;
  logic               i_valid;
  logic [ADDR_W-1:0]  i_imgLength;
  logic [N_BANKS-1:0] o_we;
  logic [ADDR_W-1:0]  o_waddr;
  logic               o_re;
  logic [ADDR_W-1:0]  o_raddr;
  logic [1:0]         o_oldest;
  logic               o_conv_valid;
  logic               o_EOP;
  logic [31:0]        o_cycles;

  modport master (
    output i_load, i_run, i_valid, i_imgLength,
    input  o_we, o_waddr, o_re, o_raddr, o_oldest, o_conv_valid, o_EOP, o_cycles
  );

  modport slave (
    input  i_load, i_run, i_valid, i_imgLength,
    output o_we, o_waddr, o_re, o_raddr, o_oldest, o_conv_valid, o_EOP, o_cycles
  );
endinterface

// File: rtl/conv_sequencer.sv
// rtl/conv_sequencer.sv - load/run sequencer for the three column banks of the 3x3 convolver
// Optional run-cycle counter on o_cycles enabled by CONV_SEQ_CYCLE_COUNT_EN.
module conv_sequencer #(
  parameter int ADDR_W  = 10,
  parameter int N_BANKS = 3
) (
  input logic             i_CLK,
  input logic             i_rst,
  conv_sequencer_if.slave bus
);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, DONE} state_t;

  state_t state, state_d;

  logic [ADDR_W-1:0]  wr_cnt, wr_cnt_d;
  logic [ADDR_W-1:0]  rd_cnt, rd_cnt_d;
  logic [1:0]         wr_bank, wr_bank_d;
  logic [1:0]         cols, cols_d;
  logic [1:0]         drain_cnt, drain_cnt_d;
  logic [ADDR_W-1:0]  len_q, len_d;
  logic [N_BANKS-1:0] we_q, we_d;
  logic [ADDR_W-1:0]  waddr_q, waddr_d;
  logic               re_q, re_d;
  logic [ADDR_W-1:0]  raddr_q, raddr_d;
  logic [1:0]         oldest_q;
  logic               cv_pipe, cv_q;
  logic               eop_q, eop_d;
  logic               run_entry;
  logic               write;

  always_ff @(posedge i_CLK) begin
    if (i_rst) state <= IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d     = state;
    wr_cnt_d    = wr_cnt;
    rd_cnt_d    = rd_cnt;
    wr_bank_d   = wr_bank;
    cols_d      = cols;
    drain_cnt_d = drain_cnt;
    len_d       = len_q;
    we_d        = '0;
    waddr_d     = waddr_q;
    re_d        = 1'b0;
    raddr_d     = '0;
    run_entry   = 1'b0;
    write       = 1'b0;

    case (state)
      IDLE: begin
        if (bus.i_load) begin
          state_d = LOAD;
          len_d   = bus.i_imgLength;
        end else if (bus.i_run) begin
          if (cols == 2'd3) run_entry = 1'b1;
          else              state_d   = DONE;
        end
      end
      LOAD: begin
        write = bus.i_valid && (len_q >= ADDR_W'(3));
        if (write) begin
          we_d    = N_BANKS'(1) << wr_bank;
          waddr_d = wr_cnt;
          if (wr_cnt == len_q - ADDR_W'(1)) begin
            wr_cnt_d  = '0;
            wr_bank_d = (wr_bank == 2'(N_BANKS - 1)) ? 2'd0 : wr_bank + 2'd1;
            cols_d    = (cols == 2'd3) ? 2'd3 : cols + 2'd1;
          end else begin
            wr_cnt_d = wr_cnt + ADDR_W'(1);
          end
        end
        // A pixel arriving together with i_run is written before the phase change.
        if (bus.i_run) begin
          if (cols == 2'd3) run_entry = 1'b1;
          else              state_d   = DONE;
        end else if (!bus.i_load) begin
          state_d  = IDLE;
          wr_cnt_d = '0;
        end
      end
      RUN: begin
        if (len_q < ADDR_W'(3)) begin
          state_d     = DRAIN;
          rd_cnt_d    = '0;
          drain_cnt_d = 2'd0;
        end else begin
          re_d    = 1'b1;
          raddr_d = rd_cnt;
          if (rd_cnt == len_q - ADDR_W'(1)) begin
            state_d     = DRAIN;
            rd_cnt_d    = '0;
            drain_cnt_d = 2'd0;
          end else begin
            rd_cnt_d = rd_cnt + ADDR_W'(1);
          end
        end
      end
      DRAIN: begin
        if (drain_cnt == 2'd2) state_d     = DONE;
        else                   drain_cnt_d = drain_cnt + 2'd1;
      end
      DONE: begin
        wr_cnt_d = '0;
        if (!bus.i_run) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Address 0 is issued on the entry edge so the first read lands one cycle after i_run.
    if (run_entry) begin
      state_d = RUN;
      len_d   = bus.i_imgLength;
      if (bus.i_imgLength >= ADDR_W'(3)) begin
        re_d     = 1'b1;
        raddr_d  = '0;
        rd_cnt_d = ADDR_W'(1);
      end else begin
        rd_cnt_d = '0;
      end
    end

    eop_d = (state_d == DONE);
  end

  always_ff @(posedge i_CLK) begin
    if (i_rst) begin
      wr_cnt    <= '0;
      rd_cnt    <= '0;
      wr_bank   <= 2'd0;
      cols      <= 2'd0;
      drain_cnt <= 2'd0;
      len_q     <= '0;
      we_q      <= '0;
      waddr_q   <= '0;
      re_q      <= 1'b0;
      raddr_q   <= '0;
      oldest_q  <= 2'd0;
      cv_pipe   <= 1'b0;
      cv_q      <= 1'b0;
      eop_q     <= 1'b0;
    end else begin
      wr_cnt    <= wr_cnt_d;
      rd_cnt    <= rd_cnt_d;
      wr_bank   <= wr_bank_d;
      cols      <= cols_d;
      drain_cnt <= drain_cnt_d;
      len_q     <= len_d;
      we_q      <= we_d;
      waddr_q   <= waddr_d;
      re_q      <= re_d;
      raddr_q   <= raddr_d;
      oldest_q  <= (cols_d == 2'd3) ? wr_bank_d : 2'd0;
      // The first two rows of a column only prime the 3x3 window.
      cv_pipe   <= re_q && (raddr_q >= ADDR_W'(2));
      cv_q      <= cv_pipe;
      eop_q     <= eop_d;
    end
  end

`ifdef CONV_SEQ_CYCLE_COUNT_EN
  logic [31:0] cycles_q;

  always_ff @(posedge i_CLK) begin
    if (i_rst)
      cycles_q <= '0;
    else if (run_entry)
      cycles_q <= '0;
    else if ((state == RUN || state == DRAIN) && cycles_q != 32'hFFFF_FFFF)
      cycles_q <= cycles_q + 32'd1;
  end

  assign bus.o_cycles = cycles_q;
`else
  assign bus.o_cycles = '0;
`endif

  assign bus.o_we         = we_q;
  assign bus.o_waddr      = waddr_q;
  assign bus.o_re         = re_q;
  assign bus.o_raddr      = raddr_q;
  assign bus.o_oldest     = oldest_q;
  assign bus.o_conv_valid = cv_q;
  assign bus.o_EOP        = eop_q;

endmodule

// File: tb/tb_conv_sequencer.sv
// tb/tb_conv_sequencer.sv - directed self-checking bench for conv_sequencer
module tb_conv_sequencer;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   cvn;

  conv_sequencer_if #(.ADDR_W(10), .N_BANKS(3)) bus ();

  conv_sequencer #(.ADDR_W(10), .N_BANKS(3)) dut (
    .i_CLK (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_cycles(input int len);
`ifdef CONV_SEQ_CYCLE_COUNT_EN
    return 32'(len + 2);
`else
    return 32'(len - len);
`endif
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_we"},     32'(bus.o_we), 0);
    check({tag, "_waddr"},  32'(bus.o_waddr), 0);
    check({tag, "_re"},     32'(bus.o_re), 0);
    check({tag, "_raddr"},  32'(bus.o_raddr), 0);
    check({tag, "_oldest"}, 32'(bus.o_oldest), 0);
    check({tag, "_cv"},     32'(bus.o_conv_valid), 0);
    check({tag, "_eop"},    32'(bus.o_EOP), 0);
    check({tag, "_cycles"}, bus.o_cycles, 0);
  endtask

  // Observation k is cycle t+k where t is the edge that first samples i_run=1.
  task automatic run_window(input string tag, input int len);
    bus.i_run = 1'b1;
    for (int k = 1; k <= len + 4; k++) begin
      tick();
      check({tag, "_re"},  32'(bus.o_re), (k >= 1 && k <= len) ? 1 : 0);
      check({tag, "_raddr"}, 32'(bus.o_raddr), (k >= 1 && k <= len) ? 32'(k - 1) : 0);
      check({tag, "_cv"},  32'(bus.o_conv_valid), (k >= 5 && k <= len + 2) ? 1 : 0);
      check({tag, "_eop"}, 32'(bus.o_EOP), (k >= len + 3) ? 1 : 0);
      if (k == len + 3) check({tag, "_cycles"}, bus.o_cycles, exp_cycles(len));
    end
    bus.i_run = 1'b0;
    tick();
    check({tag, "_eop_drop"}, 32'(bus.o_EOP), 0);
  endtask

  initial begin
    rst             = 1'b1;
    bus.i_load      = 1'b0;
    bus.i_run       = 1'b0;
    bus.i_valid     = 1'b0;
    bus.i_imgLength = 10'd4;
    tick();
    tick();
    check_idle_outputs("reset");
    rst = 1'b0;

    // Reset in the middle of a load with wr_cnt=5.
    bus.i_imgLength = 10'd8;
    bus.i_load      = 1'b1;
    tick();
    bus.i_valid = 1'b1;
    repeat (5) tick();
    bus.i_valid = 1'b0;
    check("preload_we", 32'(bus.o_we), 1);
    check("preload_waddr", 32'(bus.o_waddr), 4);
    rst = 1'b1;
    tick();
    check_idle_outputs("midreset");
    rst        = 1'b0;
    bus.i_load = 1'b0;
    tick();

    // Frame 1: 3 columns of 4; a mid-load length change must be ignored.
    bus.i_imgLength = 10'd4;
    bus.i_load      = 1'b1;
    tick();
    bus.i_imgLength = 10'd9;
    for (int i = 0; i < 12; i++) begin
      bus.i_valid = 1'b1;
      tick();
      check("f1_we", 32'(bus.o_we), 32'(1 << (i / 4)));
      check("f1_waddr", 32'(bus.o_waddr), 32'(i % 4));
      bus.i_valid = 1'b0;
      tick();
      check("f1_we_gap", 32'(bus.o_we), 0);
    end
    check("f1_oldest", 32'(bus.o_oldest), 0);
    bus.i_load      = 1'b0;
    bus.i_imgLength = 10'd4;
    tick();
    run_window("run1", 4);

    // Frame 2: one more column slides the window.
    bus.i_load = 1'b1;
    tick();
    bus.i_valid = 1'b1;
    for (int j = 0; j < 4; j++) begin
      tick();
      check("f2_we", 32'(bus.o_we), 1);
      check("f2_waddr", 32'(bus.o_waddr), 32'(j));
    end
    bus.i_valid = 1'b0;
    tick();
    check("f2_oldest", 32'(bus.o_oldest), 1);
    bus.i_load = 1'b0;
    tick();
    run_window("run2", 4);

    // Only two columns loaded: straight to DONE.
    rst = 1'b1;
    tick();
    rst             = 1'b0;
    bus.i_imgLength = 10'd3;
    bus.i_load      = 1'b1;
    tick();
    bus.i_valid = 1'b1;
    repeat (6) tick();
    bus.i_valid = 1'b0;
    bus.i_load  = 1'b0;
    tick();
    bus.i_run = 1'b1;
    tick();
    check("twocol_re", 32'(bus.o_re), 0);
    check("twocol_eop", 32'(bus.o_EOP), 1);
    tick();
    check("twocol_re2", 32'(bus.o_re), 0);
    check("twocol_eop2", 32'(bus.o_EOP), 1);
    bus.i_run = 1'b0;
    tick();
    check("twocol_eop_drop", 32'(bus.o_EOP), 0);

    // Length below 3: pixels are ignored.
    rst = 1'b1;
    tick();
    rst             = 1'b0;
    bus.i_imgLength = 10'd2;
    bus.i_load      = 1'b1;
    tick();
    bus.i_valid = 1'b1;
    for (int j = 0; j < 3; j++) begin
      tick();
      check("short_we", 32'(bus.o_we), 0);
    end
    bus.i_valid = 1'b0;
    bus.i_load  = 1'b0;
    tick();

    // Maximum length frame.
    rst = 1'b1;
    tick();
    rst             = 1'b0;
    bus.i_imgLength = 10'd1023;
    bus.i_load      = 1'b1;
    tick();
    bus.i_valid = 1'b1;
    repeat (3069) tick();
    bus.i_valid = 1'b0;
    check("big_last_we", 32'(bus.o_we), 4);
    check("big_last_waddr", 32'(bus.o_waddr), 1022);
    tick();
    check("big_oldest", 32'(bus.o_oldest), 0);
    bus.i_load = 1'b0;
    tick();
    bus.i_run = 1'b1;
    cvn = 0;
    for (int k = 1; k <= 1030; k++) begin
      tick();
      if (bus.o_conv_valid) cvn++;
      if (k == 1023) begin
        check("big_last_re", 32'(bus.o_re), 1);
        check("big_last_raddr", 32'(bus.o_raddr), 1022);
      end
      if (k == 1024) begin
        check("big_after_re", 32'(bus.o_re), 0);
        check("big_raddr_wrap", 32'(bus.o_raddr), 0);
      end
      if (k == 1025) check("big_eop_early", 32'(bus.o_EOP), 0);
      if (k == 1026) begin
        check("big_eop", 32'(bus.o_EOP), 1);
        check("big_cycles", bus.o_cycles, exp_cycles(1023));
      end
    end
    check("big_cv_count", 32'(cvn), 1021);
    bus.i_run = 1'b0;
    tick();
    check("big_eop_drop", 32'(bus.o_EOP), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
